// File: rtl/jk_drv_pkg.sv
// Shared types and constants for the JK bank driver: FSM state encoding,
// error counter width and a saturating increment helper.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FAULT = 2'd1,
    SYNC  = 2'd2
  } drv_state_e;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Increment the error counter, sticking at its maximum value
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/jk_seq_driver_if.sv
// Control/feedback bundle between the JK bank driver and its environment.
// The master side supplies controls and bank feedback, the slave side is
// the driver itself.
interface jk_seq_driver_if import jk_drv_pkg::*; #(
  parameter int WIDTH = 3
);

  logic                 en;
  logic                 up;
  logic                 load;
  logic [WIDTH-1:0]     load_val;
  logic                 halt_on_err;
  logic                 clr_err;
  logic [WIDTH-1:0]     q_fb;

  logic [WIDTH-1:0]     j;
  logic [WIDTH-1:0]     k;
  logic [WIDTH-1:0]     count;
  logic                 tc;
  logic                 mismatch;
  logic                 load_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 fault;

  modport master (
    output en, up, load, load_val, halt_on_err, clr_err, q_fb,
    input  j, k, count, tc, mismatch, load_err, err_cnt, fault
  );

  modport slave (
    input  en, up, load, load_val, halt_on_err, clr_err, q_fb,
    output j, k, count, tc, mismatch, load_err, err_cnt, fault
  );

endinterface

// File: rtl/jk_excite.sv
// Single-bit JK excitation: chooses J/K so a JK flop moves from cur to nxt.
// Don't-care entries are resolved to 0, so J=K=1 (toggle) never appears.
module jk_excite (
  input  logic cur,
  input  logic nxt,
  output logic j,
  output logic k
);

  // Set only on a 0->1 step, reset only on a 1->0 step, otherwise hold
  always_comb begin
    j = ~cur & nxt;
    k = cur & ~nxt;
  end

endmodule

// File: rtl/jk_seq_driver.sv
// Excitation-side controller for a bank of WIDTH external JK flops.
// Tracks the expected mod-MOD up/down/load count, generates J/K so the bank
// follows it, and compares the bank's Q feedback against the expected count
// every RUN cycle. Mismatches are counted and can halt the bank in FAULT,
// from which clr_err recovers through a one-cycle SYNC clear.
module jk_seq_driver import jk_drv_pkg::*; #(
  parameter int WIDTH = 3,
  parameter int MOD   = 8
) (
  input logic             CLK,
  input logic             rst_n,
  jk_seq_driver_if.slave  bus
);

  localparam logic [1:0]       ST_RUN   = RUN;
  localparam logic [1:0]       ST_FAULT = FAULT;
  localparam logic [1:0]       ST_SYNC  = SYNC;
  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W    = (WIDTH + 1)'(MOD);

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_CNT_W-1:0] err_base;

  logic [WIDTH-1:0]     nxt;
  logic                 load_rej;
  logic                 in_run;
  logic                 tc_c;
  logic                 mismatch_c;
  logic                 load_err_c;

  logic [WIDTH-1:0]     cur_x, nxt_x;
  logic [WIDTH-1:0]     j_w, k_w;

  assign in_run = (state_q == ST_RUN);

  // Next target for the bank in RUN: load (if in range) beats en, wrap at MOD
  always_comb begin
    nxt      = count_q;
    load_rej = 1'b0;
    if (bus.load) begin
      if ({1'b0, bus.load_val} < MOD_W) begin
        nxt = bus.load_val;
      end else begin
        load_rej = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up) begin
        nxt = (count_q == CNT_MAX) ? '0 : count_q + 1'b1;
      end else begin
        nxt = (count_q == '0) ? CNT_MAX : count_q - 1'b1;
      end
    end
  end

  // Status outputs, only meaningful in RUN and forced low while in reset
  always_comb begin
    tc_c       = rst_n & in_run & bus.en &
                 ((bus.up & (count_q == CNT_MAX)) | (~bus.up & (count_q == '0)));
    mismatch_c = rst_n & in_run & (bus.q_fb != count_q);
    load_err_c = rst_n & in_run & load_rej;
  end

  // Pick the (cur, nxt) pair fed to the excitation map: track in RUN, hold in
  // FAULT (same value both sides), clear every bit in SYNC, silent in reset
  always_comb begin
    cur_x = count_q;
    nxt_x = nxt;
    if (!rst_n) begin
      cur_x = '0;
      nxt_x = '0;
    end else if (state_q == ST_FAULT) begin
      cur_x = count_q;
      nxt_x = count_q;
    end else if (state_q == ST_SYNC) begin
      cur_x = '1;
      nxt_x = '0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_excite
    jk_excite u_excite (
      .cur (cur_x[i]),
      .nxt (nxt_x[i]),
      .j   (j_w[i]),
      .k   (k_w[i])
    );
  end

  // FSM, count and error counter next-state; a mismatch in the same cycle as
  // clr_err lands on top of the cleared value
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    err_base  = bus.clr_err ? '0 : err_cnt_q;
    case (state_q)
      ST_RUN: begin
        count_d   = nxt;
        err_cnt_d = mismatch_c ? sat_inc(err_base) : err_base;
        if (mismatch_c && bus.halt_on_err) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (bus.clr_err) begin
          state_d   = ST_SYNC;
          err_cnt_d = '0;
        end
      end
      ST_SYNC: begin
        count_d = '0;
        state_d = ST_RUN;
      end
      default: begin
        count_d = '0;
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers, reset together with the JK bank to count 0
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.j        = j_w;
  assign bus.k        = k_w;
  assign bus.count    = count_q;
  assign bus.tc       = tc_c;
  assign bus.mismatch = mismatch_c;
  assign bus.load_err = load_err_c;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.fault    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: two instances (MOD=8 and MOD=6, WIDTH=3) share
// the same controls, each drives its own behavioural JK bank. Outputs are
// compared against a counting model, a directed vector table and a few
// hand-written multi-cycle sequences.
module tb_jk_seq_driver;

  logic       CLK;
  logic       rst_n;

  logic       c_en, c_up, c_load, c_halt, c_clr;
  logic [2:0] c_lv;
  logic [2:0] c_inj;
  logic       c_force;
  logic [2:0] c_force_val;

  logic [2:0] bank8, bank6;

  int checks;
  int errors;

  jk_seq_driver_if #(.WIDTH(3)) if8 ();
  jk_seq_driver_if #(.WIDTH(3)) if6 ();

  jk_seq_driver #(.WIDTH(3), .MOD(8)) dut8 (.CLK(CLK), .rst_n(rst_n), .bus(if8));
  jk_seq_driver #(.WIDTH(3), .MOD(6)) dut6 (.CLK(CLK), .rst_n(rst_n), .bus(if6));

  assign if8.en = c_en;            assign if6.en = c_en;
  assign if8.up = c_up;            assign if6.up = c_up;
  assign if8.load = c_load;        assign if6.load = c_load;
  assign if8.load_val = c_lv;      assign if6.load_val = c_lv;
  assign if8.halt_on_err = c_halt; assign if6.halt_on_err = c_halt;
  assign if8.clr_err = c_clr;      assign if6.clr_err = c_clr;
  assign if8.q_fb = c_force ? c_force_val : (bank8 ^ c_inj);
  assign if6.q_fb = c_force ? c_force_val : (bank6 ^ c_inj);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural JK flop banks: Q+ = J&~Q | ~K&Q, cleared by rst_n
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      bank8 <= 3'd0;
      bank6 <= 3'd0;
    end else begin
      bank8 <= (if8.j & ~bank8) | (~if8.k & bank8);
      bank6 <= (if6.j & ~bank6) | (~if6.k & bank6);
    end
  end

  // Reference model: index 0 is MOD=8, index 1 is MOD=6.
  // mode 0 = counting, 1 = halted, 2 = one-cycle clear
  int m_cnt[2];
  int m_mode[2];
  int m_err[2];
  int m_bank[2];

  typedef struct {
    int nxt;
    int j;
    int k;
    int tc;
    int mm;
    int le;
    int fault;
  } exp_t;

  function automatic exp_t model_eval(input int d);
    exp_t e;
    int   md;
    int   cnt;
    int   qv;
    md  = (d == 0) ? 8 : 6;
    cnt = m_cnt[d];
    qv  = c_force ? int'(c_force_val) : (m_bank[d] ^ int'(c_inj));
    e   = '{default: 0};
    e.nxt = cnt;
    if (m_mode[d] == 0) begin
      if (c_load) begin
        if (int'(c_lv) < md) e.nxt = int'(c_lv);
        else                 e.le  = 1;
      end else if (c_en) begin
        if (c_up) e.nxt = (cnt + 1) % md;
        else      e.nxt = (cnt + md - 1) % md;
      end
      e.tc = (c_en && ((c_up && cnt == md - 1) || (!c_up && cnt == 0))) ? 1 : 0;
      e.mm = (qv != cnt) ? 1 : 0;
      e.j  = (~cnt) & e.nxt & 7;
      e.k  = cnt & (~e.nxt) & 7;
    end else if (m_mode[d] == 1) begin
      e.fault = 1;
    end else begin
      e.k = 7;
    end
    return e;
  endfunction

  task automatic model_step(input int d);
    exp_t e;
    int   base;
    e = model_eval(d);
    if (m_mode[d] == 0) begin
      m_cnt[d]  = e.nxt;
      m_bank[d] = e.nxt;
      base = c_clr ? 0 : m_err[d];
      if (e.mm == 1) base = (base < 255) ? base + 1 : 255;
      m_err[d] = base;
      if (e.mm == 1 && c_halt) m_mode[d] = 1;
    end else if (m_mode[d] == 1) begin
      if (c_clr) begin
        m_mode[d] = 2;
        m_err[d]  = 0;
      end
    end else begin
      m_cnt[d]  = 0;
      m_bank[d] = 0;
      m_mode[d] = 0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_mode[d] = 0; m_err[d] = 0; m_bank[d] = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output of one instance with the model
  task automatic check_output(input int d);
    exp_t  e;
    string p;
    int a_j, a_k, a_cnt, a_tc, a_mm, a_le, a_err, a_fault;
    e = model_eval(d);
    if (d == 0) begin
      p = "m8"; a_j = if8.j; a_k = if8.k; a_cnt = if8.count; a_tc = if8.tc;
      a_mm = if8.mismatch; a_le = if8.load_err; a_err = if8.err_cnt; a_fault = if8.fault;
    end else begin
      p = "m6"; a_j = if6.j; a_k = if6.k; a_cnt = if6.count; a_tc = if6.tc;
      a_mm = if6.mismatch; a_le = if6.load_err; a_err = if6.err_cnt; a_fault = if6.fault;
    end
    check({p, ".count"},    a_cnt,   m_cnt[d]);
    check({p, ".j"},        a_j,     e.j);
    check({p, ".k"},        a_k,     e.k);
    check({p, ".tc"},       a_tc,    e.tc);
    check({p, ".mismatch"}, a_mm,    e.mm);
    check({p, ".load_err"}, a_le,    e.le);
    check({p, ".err_cnt"},  a_err,   m_err[d]);
    check({p, ".fault"},    a_fault, e.fault);
  endtask

  task automatic apply_stimulus(input logic en, input logic up, input logic load,
                                input logic [2:0] lv, input logic halt,
                                input logic clr, input logic [2:0] inj);
    c_en = en; c_up = up; c_load = load; c_lv = lv;
    c_halt = halt; c_clr = clr; c_inj = inj;
  endtask

  // Let combinational outputs settle after the negedge, then compare
  task automatic settle_and_check();
    #1;
    check_output(0);
    check_output(1);
  endtask

  // Cross the rising edge, advance the model, return to the next negedge
  task automatic advance();
    @(posedge CLK);
    model_step(0);
    model_step(1);
    @(negedge CLK);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".count8"}, if8.count, 0);    check({tag, ".count6"}, if6.count, 0);
    check({tag, ".j8"}, if8.j, 0);            check({tag, ".k8"}, if8.k, 0);
    check({tag, ".j6"}, if6.j, 0);            check({tag, ".k6"}, if6.k, 0);
    check({tag, ".tc8"}, if8.tc, 0);          check({tag, ".tc6"}, if6.tc, 0);
    check({tag, ".mm8"}, if8.mismatch, 0);    check({tag, ".le8"}, if8.load_err, 0);
    check({tag, ".err8"}, if8.err_cnt, 0);    check({tag, ".err6"}, if6.err_cnt, 0);
    check({tag, ".fault8"}, if8.fault, 0);    check({tag, ".fault6"}, if6.fault, 0);
  endtask

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic [2:0] lv;
    int         c8;
    int         j8;
    int         k8;
    int         tc8;
    int         c6;
    int         le6;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // en up ld lv   c8 j8 k8 tc8  c6 le6
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1, 2, 1, 0, 1, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 3'd0, 2, 1, 0, 0, 2, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 3'd0, 3, 4, 3, 0, 3, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 3'd0, 4, 1, 0, 0, 4, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 3'd0, 5, 2, 1, 0, 5, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 3'd0, 6, 1, 0, 0, 0, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 3'd0, 7, 0, 7, 1, 1, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 3'd0, 0, 1, 0, 0, 2, 0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1, 2, 1, 0, 3, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 3'd0, 2, 0, 2, 0, 4, 0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 3'd0, 0, 7, 0, 1, 0, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 3'd0, 7, 0, 1, 0, 5, 0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 3'd0, 6, 1, 2, 0, 4, 0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 3'd5, 5, 0, 0, 0, 3, 0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 3'd6, 5, 2, 1, 0, 5, 1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 3'd0, 6, 0, 0, 0, 5, 0};

    checks = 0;
    errors = 0;
    c_force = 1'b0;
    c_force_val = 3'd0;
    model_reset();

    // Reset with en/down active: ungated outputs would show j=111 and tc=1
    rst_n = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    repeat (2) @(negedge CLK);
    #1;
    check_reset_values("reset");
    @(negedge CLK);
    rst_n = 1'b1;

    // Directed table: count up with wrap, load 0, count down with wrap, load/reject
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].lv, 1'b0, 1'b0, 3'd0);
      settle_and_check();
      check($sformatf("tbl%0d.count8", i), if8.count, tbl[i].c8);
      check($sformatf("tbl%0d.j8", i), if8.j, tbl[i].j8);
      check($sformatf("tbl%0d.k8", i), if8.k, tbl[i].k8);
      check($sformatf("tbl%0d.tc8", i), if8.tc, tbl[i].tc8);
      check($sformatf("tbl%0d.mm8", i), if8.mismatch, 0);
      check($sformatf("tbl%0d.count6", i), if6.count, tbl[i].c6);
      check($sformatf("tbl%0d.le6", i), if6.load_err, tbl[i].le6);
      advance();
    end

    // Fault recovery: corrupt q_fb[1] for one cycle with halt enabled
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'b010);
    settle_and_check();
    check("flt.mm8", if8.mismatch, 1);
    check("flt.mm6", if6.mismatch, 1);
    advance();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 3'd0);
      settle_and_check();
      check("flt.fault8", if8.fault, 1);
      check("flt.j8", if8.j, 0);
      check("flt.k8", if8.k, 0);
      check("flt.err8", if8.err_cnt, 1);
      check("flt.count8", if8.count, 7);
      advance();
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0);
    settle_and_check();
    check("clr.fault8", if8.fault, 1);
    advance();
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    settle_and_check();
    check("sync.k8", if8.k, 7);
    check("sync.j8", if8.j, 0);
    check("sync.fault8", if8.fault, 0);
    check("sync.err8", if8.err_cnt, 0);
    advance();
    settle_and_check();
    check("post.count8", if8.count, 0);
    check("post.count6", if6.count, 0);
    check("post.fault8", if8.fault, 0);

    // Error counting without halt: q_fb stuck at 0 while counting continues
    c_force = 1'b1;
    c_force_val = 3'd0;
    for (int i = 0; i < 320; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
      settle_and_check();
      advance();
    end
    #1;
    check("sat.err8", if8.err_cnt, 255);
    check("sat.err6", if6.err_cnt, 255);
    check("sat.fault8", if8.fault, 0);
    check("sat.fault6", if6.fault, 0);
    c_force = 1'b0;

    // Reset mid-run: load 5, then drop rst_n between edges
    apply_stimulus(1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0);
    settle_and_check();
    advance();
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    settle_and_check();
    check("pre_rst.count8", if8.count, 5);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(negedge CLK);
    rst_n = 1'b1;
    settle_and_check();
    check("restart.count8", if8.count, 0);
    advance();
    settle_and_check();
    check("restart.count8b", if8.count, 1);
    check("restart.count6b", if6.count, 1);
    advance();

    // Randomized controls against the model
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(3) != 0),
                     1'($urandom_range(1)),
                     ($urandom_range(7) == 0),
                     3'($urandom_range(7)),
                     1'($urandom_range(1)),
                     ($urandom_range(7) == 0),
                     ($urandom_range(15) == 0) ? 3'($urandom_range(7)) : 3'd0);
      settle_and_check();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_seq_driver.md
# jk_seq_driver

Excitation-side controller for a bank of WIDTH external JK flip-flops that share CLK and rst_n. Each cycle it computes J/K for every bit so that the bank steps through a mod-MOD up/down/load count. It keeps its own expected count and compares it against the Q feedback on every cycle. On a mismatch it reports an error and can halt the bank. It is the driving end of the JK bank used in the counter experiments.

## Interface
- WIDTH, 3, number of JK flops driven; 1..8
- MOD, 8, count modulus; 2..2^WIDTH
- CLK  in  1  clock, shared with the JK bank
- rst_n  in  1  reset, asynchronous, active-low; also resets the JK bank
- en  in  1  advance count this cycle
- up  in  1  1 = increment, 0 = decrement; sampled only when en=1
- load  in  1  load load_val this cycle; priority over en
- load_val  in  WIDTH  value to load
- halt_on_err  in  1  1 = enter FAULT on mismatch
- clr_err  in  1  leave FAULT, clear err_cnt
- q_fb  in  WIDTH  Q outputs of the JK bank
- j  out  WIDTH  J inputs to the bank (combinational from state and controls)
- k  out  WIDTH  K inputs to the bank (combinational from state and controls)
- count  out  WIDTH  expected count (registered)
- tc  out  1  terminal count: en & up & count==MOD-1, or en & ~up & count==0 (combinational)
- mismatch  out  1  one-cycle pulse when q_fb != count
- load_err  out  1  one-cycle pulse when load_val >= MOD
- err_cnt  out  8  saturating mismatch counter
- fault  out  1  high in FAULT

## Operation
- States: RUN, FAULT, SYNC. Reset enters RUN with count=0, matching the bank's reset value of 0.
- Next target `nxt` in RUN, highest priority first:
  - load with load_val<MOD: nxt=load_val.
  - load with load_val>=MOD: nxt=count and load_err=1.
  - en & up: nxt = (count==MOD-1) ? 0 : count+1.
  - en & ~up: nxt = (count==0) ? MOD-1 : count-1.
  - otherwise: nxt=count.
- Excitation per bit i, from count[i] to nxt[i]. Don't-cares are resolved as 0.
  - 0→0: J=0, K=0
  - 0→1: J=1, K=0
  - 1→0: J=0, K=1
  - 1→1: J=0, K=0
- The J=K=1 (toggle) encoding is never emitted.
- count <= nxt on every rising edge in RUN.
- Check, in RUN only:
  - If q_fb != count, pulse mismatch and increment err_cnt, saturating at 255.
  - If halt_on_err=1 as well, go to FAULT.
  - Mismatch in the same cycle as load still counts.
- FAULT:
  - j=0, k=0, so the bank holds.
  - count, en, up and load are frozen.
  - Checking is suppressed.
  - On clr_err, go to SYNC and set err_cnt=0.
- SYNC lasts one cycle: j=0, k=all ones (bank clears), then count <= 0 and the state returns to RUN.
- clr_err in RUN clears err_cnt only.

## Timing
- Reset values: j=0, k=0, count=0, tc=0, mismatch=0, load_err=0, err_cnt=0, fault=0.
- Reset is asynchronous: all of the above take effect immediately, regardless of state.
- j and k are valid within the same cycle and are sampled by the bank at the next edge. The bank and count update on the same edge.
- Compare latency is zero: q_fb is checked against count in the cycle after the update. A corrupted bank bit is therefore flagged one cycle after the edge that produced it.
- Wrap-around: up from MOD-1 gives 0, and down from 0 gives MOD-1, for any MOD, including non-power-of-two values.
- Simultaneous events:
  - load beats en.
  - A mismatch in the cycle clr_err is asserted (RUN) still increments err_cnt after the clear, so err_cnt=1.
  - Deasserting halt_on_err in FAULT has no effect; only clr_err exits FAULT.

## Structure
- Package jk_drv_pkg holds the state enum (RUN, FAULT, SYNC) and the err_cnt width constant (8).
- Sub-module jk_excite is the per-bit combinational map from (cur, nxt) to (J, K). It is instantiated WIDTH times with a generate loop.
- The top level holds the FSM, the nxt mux, the count register, the checker and err_cnt.

## Test plan
- Count up: rst, en=1, up=1, 10 cycles against a behavioural JK bank model → count/q_fb go 0..7,0,1. At count=3, j=100 and k=011. tc is high at count 7. mismatch stays 0.
- Count down and wrap: rst, en=1, up=0 → count goes 0,7,6. At count=0, j=111, k=000, tc=1.
- Load and reject: with MOD=6 and WIDTH=3, load=1, load_val=5, en=1 → next count=5. Then load_val=6 → load_err pulses and count holds at 5.
- Fault recovery: halt_on_err=1, force q_fb[1] inverted for one cycle → mismatch, err_cnt=1, fault=1, j=k=0 for 3 cycles. Then clr_err → one SYNC cycle (k=111), then count=0, fault=0, err_cnt=0.
- Error counting without halt: halt_on_err=0, keep q_fb stuck for 300 cycles → err_cnt saturates at 255, fault stays 0, and counting continues.
- Reset mid-run: rst_n low at count=5 between edges → j=0, k=0, count=0, err_cnt=0 immediately. After release, counting restarts from 0.
